// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S record-path capture block.
package i2s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_SKIP,
    ST_SHIFT,
    ST_HOLD,
    ST_WRITE
  } state_e;

  localparam int DEF_SAMPLE_BITS = 24;
  localparam int DEF_BUF_WORDS   = 1024;
  localparam int WORD_STRIDE     = 4;

endpackage

// File: rtl/i2s_edge_sync.sv
// Two-flop synchronizer for one asynchronous I2S line, followed by an
// edge-detect flop that yields single-cycle rise/fall pulses in the clk domain.
module i2s_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] synchronizer stages, [2] previous synchronized level
  logic [2:0] sr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[1:0], async_i};
    end
  end

  assign level_o = sr_q[1];
  assign rise_o  = sr_q[1] & ~sr_q[2];
  assign fall_o  = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/i2s_rx_bram_writer.sv
// I2S record capture into a BRAM ring buffer. Define I2S_RX_PACK16_EN to pack
// the top 16 bits of both channels into one word per frame.
module i2s_rx_bram_writer
  import i2s_pkg::*;
#(
  parameter int          SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int          BUF_WORDS   = DEF_BUF_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         capture_en,
  input  logic                         audio_I2S_bclk,
  input  logic                         audio_I2S_reclrc,
  input  logic                         audio_I2S_recdat,
  output logic [31:0]                  BRAM_addr,
  output logic                         BRAM_clk,
  output logic [31:0]                  BRAM_din,
  input  logic [31:0]                  BRAM_dout,
  output logic                         BRAM_en,
  output logic                         BRAM_rst,
  output logic [3:0]                   BRAM_we,
  output logic [$clog2(BUF_WORDS)-1:0] wr_index,
  output logic                         frame_strobe,
  output logic                         short_word
);

  localparam int IDX_W = $clog2(BUF_WORDS);
  localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
  localparam logic [CNT_W-1:0] BIT_TOP = CNT_W'(SAMPLE_BITS - 1);

  logic bclk_lvl, bclk_rise, bclk_fall;
  logic lr_lvl, lr_rise, lr_fall;
  logic dat_lvl, dat_rise, dat_fall;

  i2s_edge_sync u_sync_bclk (
    .clk    (clk),
    .rstn   (rstn),
    .async_i(audio_I2S_bclk),
    .level_o(bclk_lvl),
    .rise_o (bclk_rise),
    .fall_o (bclk_fall)
  );

  i2s_edge_sync u_sync_lr (
    .clk    (clk),
    .rstn   (rstn),
    .async_i(audio_I2S_reclrc),
    .level_o(lr_lvl),
    .rise_o (lr_rise),
    .fall_o (lr_fall)
  );

  i2s_edge_sync u_sync_dat (
    .clk    (clk),
    .rstn   (rstn),
    .async_i(audio_I2S_recdat),
    .level_o(dat_lvl),
    .rise_o (dat_rise),
    .fall_o (dat_fall)
  );

  state_e                 state_q, state_d;
  logic                   chan_q, chan_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] sr_q, sr_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [31:0]            din_q, din_d;
  logic [31:0]            addr_q, addr_d;
  logic                   short_q, short_d;
  logic                   cap_q;
  logic                   cap_rise;
  logic                   lr_edge;
  logic                   last_word;
`ifndef I2S_RX_PACK16_EN
  logic [SAMPLE_BITS-1:0] right_q, right_d;
  logic                   wsel_q, wsel_d;
`endif

  logic unused_sink;
`ifdef I2S_RX_PACK16_EN
  assign unused_sink = ^{BRAM_dout, bclk_lvl, bclk_fall, dat_rise, dat_fall,
                         left_q[SAMPLE_BITS-17:0]};
`else
  assign unused_sink = ^{BRAM_dout, bclk_lvl, bclk_fall, dat_rise, dat_fall};
`endif

  function automatic logic [31:0] sext(input logic [SAMPLE_BITS-1:0] s);
    return {{(32 - SAMPLE_BITS){s[SAMPLE_BITS-1]}}, s};
  endfunction

  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + 32'(WORD_STRIDE) * 32'(idx);
  endfunction

  // The word clock is launched on a bclk falling edge, so its synchronized edge
  // always precedes the next bclk rise, which carries the one-bit I2S delay slot.
  assign lr_edge  = lr_rise | lr_fall;
  assign cap_rise = capture_en & ~cap_q;

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    left_d       = left_q;
    idx_d        = idx_q;
    din_d        = din_q;
    addr_d       = addr_q;
    short_d      = short_q;
    last_word    = 1'b0;
`ifndef I2S_RX_PACK16_EN
    right_d      = right_q;
    wsel_d       = wsel_q;
`endif
    BRAM_en      = 1'b0;
    BRAM_we      = 4'h0;
    frame_strobe = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (capture_en && lr_fall) begin
          state_d = ST_SKIP;
          chan_d  = 1'b0;
        end else if (cap_rise && lr_lvl) begin
          state_d = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        if (!capture_en) begin
          state_d = ST_IDLE;
        end else if (lr_fall) begin
          state_d = ST_SKIP;
          chan_d  = 1'b0;
        end
      end

      ST_SKIP: begin
        if (bclk_rise) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end

      ST_SHIFT, ST_HOLD: begin
        if (lr_edge) begin
          // sr_q is cleared on entry, so an early end leaves the LSBs zero
          if (state_q == ST_SHIFT) short_d = 1'b1;
          if (!chan_q) begin
            left_d  = sr_q;
            chan_d  = 1'b1;
            state_d = ST_SKIP;
          end else begin
            chan_d  = 1'b0;
            state_d = ST_WRITE;
            addr_d  = word_addr(idx_q);
`ifdef I2S_RX_PACK16_EN
            din_d   = {left_q[SAMPLE_BITS-1 -: 16], sr_q[SAMPLE_BITS-1 -: 16]};
`else
            din_d   = sext(left_q);
            right_d = sr_q;
            wsel_d  = 1'b0;
`endif
          end
        end else if (state_q == ST_SHIFT && bclk_rise) begin
          sr_d[BIT_TOP - cnt_q] = dat_lvl;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BIT_TOP) state_d = ST_HOLD;
        end
      end

      ST_WRITE: begin
        BRAM_en = 1'b1;
        BRAM_we = 4'hF;
        idx_d   = idx_q + IDX_W'(1);
`ifdef I2S_RX_PACK16_EN
        last_word = 1'b1;
`else
        last_word = wsel_q;
        wsel_d    = ~wsel_q;
        if (!wsel_q) begin
          din_d  = sext(right_q);
          addr_d = word_addr(idx_q + IDX_W'(1));
        end
`endif
        if (last_word) begin
          frame_strobe = 1'b1;
          state_d      = capture_en ? ST_SKIP : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      chan_q  <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      left_q  <= '0;
      idx_q   <= '0;
      din_q   <= '0;
      addr_q  <= '0;
      short_q <= 1'b0;
      cap_q   <= 1'b0;
`ifndef I2S_RX_PACK16_EN
      right_q <= '0;
      wsel_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      left_q  <= left_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      short_q <= short_d;
      cap_q   <= capture_en;
`ifndef I2S_RX_PACK16_EN
      right_q <= right_d;
      wsel_q  <= wsel_d;
`endif
    end
  end

  assign BRAM_clk   = clk;
  assign BRAM_rst   = 1'b0;
  assign BRAM_din   = din_q;
  assign BRAM_addr  = addr_q;
  assign wr_index   = idx_q;
  assign short_word = short_q;

endmodule

// File: tb/tb_i2s_rx_bram_writer.sv
// Randomized I2S record stream against a frame-level reference model of the
// expected BRAM writes (addresses, data, strobes, short-word flag).
module tb_i2s_rx_bram_writer;

  localparam int BW   = 4;
  localparam int HALF = 80;
`ifdef I2S_RX_PACK16_EN
  localparam int WPF = 1;
`else
  localparam int WPF = 2;
`endif

  logic        clk = 1'b0;
  logic        rstn, capture_en, bclk, lrc, dat;
  logic [31:0] BRAM_addr, BRAM_din, BRAM_dout;
  logic        BRAM_clk, BRAM_en, BRAM_rst;
  logic [3:0]  BRAM_we;
  logic [1:0]  wr_index;
  logic        frame_strobe, short_word;

  i2s_rx_bram_writer #(
    .SAMPLE_BITS(24),
    .BUF_WORDS  (BW),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .capture_en      (capture_en),
    .audio_I2S_bclk  (bclk),
    .audio_I2S_reclrc(lrc),
    .audio_I2S_recdat(dat),
    .BRAM_addr       (BRAM_addr),
    .BRAM_clk        (BRAM_clk),
    .BRAM_din        (BRAM_din),
    .BRAM_dout       (BRAM_dout),
    .BRAM_en         (BRAM_en),
    .BRAM_rst        (BRAM_rst),
    .BRAM_we         (BRAM_we),
    .wr_index        (wr_index),
    .frame_strobe    (frame_strobe),
    .short_word      (short_word)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  wr_t         mw;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          exp_words  = 0;
  int          exp_frames = 0;
  int          seen_frames = 0;
  logic        short_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: samples keep their top n bits, frames map to words.
  function automatic logic [23:0] trunc(input logic [23:0] v, input int n);
    logic [23:0] low;
    low = 24'(24'h1 << (24 - n)) - 24'h1;
    return v & ~low;
  endfunction

  task automatic push_word(input logic [31:0] d, input logic last);
    wr_t w;
    w.addr = 32'((exp_words % BW) * 4);
    w.data = d;
    w.last = last;
    exp_q.push_back(w);
    exp_words++;
  endtask

  task automatic model_frame(input logic [23:0] l, input logic [23:0] r);
`ifdef I2S_RX_PACK16_EN
    push_word({l[23:8], r[23:8]}, 1'b1);
`else
    push_word({{8{l[23]}}, l}, 1'b0);
    push_word({{8{r[23]}}, r}, 1'b1);
`endif
    exp_frames++;
  endtask

  always @(negedge clk) begin
    if (rstn && (BRAM_en || frame_strobe)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", {30'd0, BRAM_en, frame_strobe}, 32'd0);
      end else begin
        mw = exp_q.pop_front();
        chk("wr_en",   {31'd0, BRAM_en}, 32'd1);
        chk("wr_we",   {28'd0, BRAM_we}, 32'hF);
        chk("wr_addr", BRAM_addr, mw.addr);
        chk("wr_data", BRAM_din, mw.data);
        chk("strobe",  {31'd0, frame_strobe}, {31'd0, mw.last});
        log_addr.push_back(BRAM_addr);
        log_data.push_back(BRAM_din);
      end
      if (frame_strobe) seen_frames++;
    end
  end

  task automatic slot(input logic lr, input logic d);
    bclk = 1'b0;
    lrc  = lr;
    dat  = d;
    #(HALF);
    bclk = 1'b1;
    #(HALF);
  endtask

  task automatic send_chan(input logic lr, input logic [23:0] v, input int n, input int pad);
    slot(lr, 1'($urandom_range(0, 1)));
    for (int i = 0; i < n; i++) slot(lr, v[23-i]);
    for (int i = 0; i < pad; i++) slot(lr, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            input int nl, input int nr,
                            input bit drop_mid, input bit rst_mid);
    logic cap;
    int   pl, pr;
    cap = capture_en;
    pl  = (nl == 24) ? int'($urandom_range(0, 7)) : 0;
    pr  = (nr == 24) ? int'($urandom_range(0, 7)) : 0;
    if (drop_mid) begin
      fork
        send_chan(1'b0, l, nl, pl);
        begin #(HALF * 2 * 10); capture_en = 1'b0; end
      join
    end else begin
      send_chan(1'b0, l, nl, pl);
    end
    chk("q_drained",  32'(exp_q.size()), 32'd0);
    chk("wr_index",   {30'd0, wr_index}, 32'(exp_words % BW));
    chk("short_word", {31'd0, short_word}, {31'd0, short_exp});
    if (rst_mid) begin
      for (int i = 0; i < 10; i++) slot(1'b1, 1'($urandom_range(0, 1)));
      rstn = 1'b0;
      #1;
      chk("rst_en",     {31'd0, BRAM_en}, 32'd0);
      chk("rst_we",     {28'd0, BRAM_we}, 32'd0);
      chk("rst_din",    BRAM_din, 32'd0);
      chk("rst_addr",   BRAM_addr, 32'd0);
      chk("rst_idx",    {30'd0, wr_index}, 32'd0);
      chk("rst_strobe", {31'd0, frame_strobe}, 32'd0);
      chk("rst_short",  {31'd0, short_word}, 32'd0);
      #29;
      rstn      = 1'b1;
      exp_words = 0;
      short_exp = 1'b0;
      for (int i = 0; i < 15; i++) slot(1'b1, 1'($urandom_range(0, 1)));
    end else begin
      send_chan(1'b1, r, nr, pr);
      if (cap) begin
        model_frame(trunc(l, nl), trunc(r, nr));
        if (nl < 24 || nr < 24) short_exp = 1'b1;
      end
    end
  endtask

  task automatic rand_frame();
    int nl, nr;
    nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 23)) : 24;
    nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 23)) : 24;
    send_frame(24'($urandom), 24'($urandom), nl, nr, 1'b0, 1'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] wrap_a [6];
    wrap_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4};
    rstn       = 1'b0;
    capture_en = 1'b0;
    bclk       = 1'b0;
    lrc        = 1'b1;
    dat        = 1'b0;
    BRAM_dout  = $urandom;
    #30;
    chk("reset_en",    {31'd0, BRAM_en}, 32'd0);
    chk("reset_din",   BRAM_din, 32'd0);
    chk("reset_idx",   {30'd0, wr_index}, 32'd0);
    chk("reset_short", {31'd0, short_word}, 32'd0);
    chk("bram_rst",    {31'd0, BRAM_rst}, 32'd0);
    #20;
    rstn = 1'b1;

    // enable capture while the word clock sits high (right slot)
    for (int i = 0; i < 4; i++) slot(1'b1, 1'b0);
    capture_en = 1'b1;
    for (int i = 0; i < 6; i++) slot(1'b1, 1'b0);

    send_frame(24'h123456, 24'hABCDEF, 24, 24, 1'b0, 1'b0);
    send_frame(24'($urandom), 24'($urandom), 24, 24, 1'b0, 1'b0);
    send_frame(24'($urandom), 24'($urandom), 24, 24, 1'b0, 1'b0);
    send_frame(24'hFFFFFF, 24'($urandom), 20, 24, 1'b0, 1'b0);

    chk("log_len_3f", 32'(log_data.size()), 32'(3 * WPF));
    chk("strobes_3f", 32'(seen_frames), 32'd3);
`ifdef I2S_RX_PACK16_EN
    chk("pack_word0", log_data[0], 32'h1234ABCD);
    chk("pack_addr0", log_addr[0], 32'h0);
`else
    chk("left_word",  log_data[0], 32'h00123456);
    chk("right_word", log_data[1], 32'hFFABCDEF);
    for (int i = 0; i < 6; i++) chk($sformatf("wrap_addr%0d", i), log_addr[i], wrap_a[i]);
    chk("wrap_index", {30'd0, wr_index}, 32'd2);
`endif

    rand_frame();
`ifndef I2S_RX_PACK16_EN
    chk("short_left_word", log_data[6], 32'hFFFFFFF0);
`endif
    chk("short_sticky", {31'd0, short_word}, 32'd1);
    for (int f = 0; f < 5; f++) rand_frame();

    send_frame(24'($urandom), 24'($urandom), 24, 24, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) rand_frame();

    send_frame(24'($urandom), 24'($urandom), 24, 24, 1'b1, 1'b0);
    send_frame(24'($urandom), 24'($urandom), 24, 24, 1'b0, 1'b0);
    send_chan(1'b0, 24'h0, 4, 0);
    #2000;

    chk("final_q",      32'(exp_q.size()), 32'd0);
    chk("final_frames", 32'(seen_frames), 32'(exp_frames));
    chk("final_idx",    {30'd0, wr_index}, 32'(exp_words % BW));
    chk("final_en",     {31'd0, BRAM_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
